// File: rtl/tmr_vote_ctrl.sv
// Triple-modular-redundancy controller: bitwise 2-of-3 voter with per-channel
// mismatch tracking and TMR -> DMR -> FAIL degradation.
module tmr_vote_ctrl #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned MISMATCH_LIMIT = 3,
   parameter int unsigned CNT_W          = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] ch_a,
   input  logic [WIDTH-1:0] ch_b,
   input  logic [WIDTH-1:0] ch_c,
   input  logic             clr_fault,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       fault,
   output logic [1:0]       mode,
   output logic             disagree,
   output logic             err
);

   typedef enum logic [1:0] {
      S_TMR  = 2'b00,
      S_DMR  = 2'b01,
      S_FAIL = 2'b10
   } mode_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MISMATCH_LIMIT);

   mode_t            mode_q, mode_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [2:0]       fault_q, fault_d;
   logic             disagree_q, disagree_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c;
   logic [CNT_W-1:0] cnt_a_d, cnt_b_d, cnt_c_d;

   logic [WIDTH-1:0] vote;
   logic             mis_a, mis_b, mis_c;
   logic [2:0]       hit;
   logic [WIDTH-1:0] pair_p, pair_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      sat_inc = (c >= LIMIT) ? LIMIT : c + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= S_TMR;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         fault_q     <= '0;
         disagree_q  <= 1'b0;
         err_q       <= 1'b0;
         cnt_a       <= '0;
         cnt_b       <= '0;
         cnt_c       <= '0;
      end else begin
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         fault_q     <= fault_d;
         disagree_q  <= disagree_d;
         err_q       <= err_d;
         cnt_a       <= cnt_a_d;
         cnt_b       <= cnt_b_d;
         cnt_c       <= cnt_c_d;
      end
   end

   always_comb begin
      vote        = (ch_a & ch_b) | (ch_a & ch_c) | (ch_b & ch_c);
      mis_a       = (ch_a != vote);
      mis_b       = (ch_b != vote);
      mis_c       = (ch_c != vote);
      hit         = '0;
      pair_p      = ch_a;
      pair_q      = ch_b;
      mode_d      = mode_q;
      out_valid_d = in_valid;
      out_data_d  = out_data_q;
      fault_d     = fault_q;
      disagree_d  = 1'b0;
      err_d       = 1'b0;
      cnt_a_d     = cnt_a;
      cnt_b_d     = cnt_b;
      cnt_c_d     = cnt_c;

      if (clr_fault) begin
         // A sample arriving with the clear is voted 3-way but never counted.
         mode_d  = S_TMR;
         fault_d = '0;
         cnt_a_d = '0;
         cnt_b_d = '0;
         cnt_c_d = '0;
         if (in_valid) begin
            out_data_d = vote;
            disagree_d = mis_a | mis_b | mis_c;
         end
      end else if (in_valid) begin
         case (mode_q)
            S_TMR: begin
               out_data_d = vote;
               disagree_d = mis_a | mis_b | mis_c;
               cnt_a_d    = mis_a ? sat_inc(cnt_a) : '0;
               cnt_b_d    = mis_b ? sat_inc(cnt_b) : '0;
               cnt_c_d    = mis_c ? sat_inc(cnt_c) : '0;
               hit        = {cnt_c_d == LIMIT, cnt_b_d == LIMIT, cnt_a_d == LIMIT};
               fault_d    = fault_q | hit;
               if ($countones(hit) > 1)
                  mode_d = S_FAIL;
               else if (hit != 3'b000)
                  mode_d = S_DMR;
            end
            S_DMR: begin
               case (fault_q)
                  3'b001:  begin pair_p = ch_b; pair_q = ch_c; end
                  3'b010:  begin pair_p = ch_a; pair_q = ch_c; end
                  default: begin pair_p = ch_a; pair_q = ch_b; end
               endcase
               if (pair_p == pair_q) begin
                  out_data_d = pair_p;
                  if (!fault_q[0]) cnt_a_d = '0;
                  if (!fault_q[1]) cnt_b_d = '0;
                  if (!fault_q[2]) cnt_c_d = '0;
               end else begin
                  err_d      = 1'b1;
                  disagree_d = 1'b1;
               end
            end
            default: begin
               err_d = 1'b1;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign fault     = fault_q;
   assign mode      = mode_q;
   assign disagree  = disagree_q;
   assign err       = err_q;

endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// Directed self-checking bench for tmr_vote_ctrl (default limit and limit=1 instances).
module tb_tmr_vote_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_valid1;
   logic       clr_fault, clr1;
   logic [7:0] ch_a, ch_b, ch_c;

   logic       out_valid, disagree, err;
   logic [7:0] out_data;
   logic [2:0] fault;
   logic [1:0] mode;

   logic       out_valid1, disagree1, err1;
   logic [7:0] out_data1;
   logic [2:0] fault1;
   logic [1:0] mode1;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   tmr_vote_ctrl #(.WIDTH(8), .MISMATCH_LIMIT(3), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .clr_fault(clr_fault),
      .out_valid(out_valid), .out_data(out_data), .fault(fault),
      .mode(mode), .disagree(disagree), .err(err)
   );

   tmr_vote_ctrl #(.WIDTH(8), .MISMATCH_LIMIT(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
      .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .clr_fault(clr1),
      .out_valid(out_valid1), .out_data(out_data1), .fault(fault1),
      .mode(mode1), .disagree(disagree1), .err(err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a sample to the main instance, clock it, settle 1 time unit after the edge.
   task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic clr);
      in_valid  = v;
      ch_a      = a;
      ch_b      = b;
      ch_c      = c;
      clr_fault = clr;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      clr_fault = 1'b0;
   endtask

   task automatic step1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      in_valid1 = 1'b1;
      ch_a      = a;
      ch_b      = b;
      ch_c      = c;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
      clr_fault = 1'b0; clr1 = 1'b0;
      ch_a = '0; ch_b = '0; ch_c = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_fault", {29'd0, fault}, 32'd0);
      chk("rst_mode", {30'd0, mode}, 32'd0);
      rst_n = 1'b1;

      // Unanimous channels, back-to-back.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0);
         chk("agree_valid", {31'd0, out_valid}, 32'd1);
         chk("agree_data", {24'd0, out_data}, 32'h5A);
         chk("agree_disagree", {31'd0, disagree}, 32'd0);
      end
      chk("agree_fault", {29'd0, fault}, 32'd0);
      chk("agree_mode", {30'd0, mode}, 32'd0);
      step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      chk("idle_valid", {31'd0, out_valid}, 32'd0);

      // Bitwise majority with two channels wrong on different bits.
      step(1'b1, 8'h0F, 8'hF0, 8'hFF, 1'b0);
      chk("maj_data", {24'd0, out_data}, 32'hFF);
      chk("maj_disagree", {31'd0, disagree}, 32'd1);
      chk("maj_cnt_a", {28'd0, dut.cnt_a}, 32'd1);
      chk("maj_cnt_b", {28'd0, dut.cnt_b}, 32'd1);
      chk("maj_cnt_c", {28'd0, dut.cnt_c}, 32'd0);
      chk("maj_fault", {29'd0, fault}, 32'd0);

      // Channel C wrong three times -> retired, DMR.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h33, 8'h33, 8'h00, 1'b0);
         chk("cwrong_data", {24'd0, out_data}, 32'h33);
      end
      chk("cwrong_cnt_a", {28'd0, dut.cnt_a}, 32'd0);
      chk("cwrong_fault", {29'd0, fault}, 32'd4);
      chk("cwrong_mode", {30'd0, mode}, 32'd1);

      step(1'b1, 8'h11, 8'h22, 8'h33, 1'b0);
      chk("dmr_split_err", {31'd0, err}, 32'd1);
      chk("dmr_split_dis", {31'd0, disagree}, 32'd1);
      chk("dmr_split_data", {24'd0, out_data}, 32'h33);
      chk("dmr_split_mode", {30'd0, mode}, 32'd1);

      step(1'b1, 8'h55, 8'h55, 8'h99, 1'b0);
      chk("dmr_agree_data", {24'd0, out_data}, 32'h55);
      chk("dmr_agree_err", {31'd0, err}, 32'd0);
      chk("dmr_cnt_c_frozen", {28'd0, dut.cnt_c}, 32'd3);

      // Clear together with a sample.
      step(1'b1, 8'hAA, 8'hAA, 8'hAA, 1'b1);
      chk("clr_fault", {29'd0, fault}, 32'd0);
      chk("clr_mode", {30'd0, mode}, 32'd0);
      chk("clr_data", {24'd0, out_data}, 32'hAA);
      chk("clr_valid", {31'd0, out_valid}, 32'd1);
      chk("clr_cnt_c", {28'd0, dut.cnt_c}, 32'd0);

      // Channel A: wrong, wrong, right, wrong, wrong.
      step(1'b1, 8'h00, 8'h44, 8'h44, 1'b0);
      step(1'b1, 8'h00, 8'h44, 8'h44, 1'b0);
      chk("a_run_cnt2", {28'd0, dut.cnt_a}, 32'd2);
      step(1'b1, 8'h44, 8'h44, 8'h44, 1'b0);
      chk("a_run_cnt0", {28'd0, dut.cnt_a}, 32'd0);
      step(1'b1, 8'h00, 8'h44, 8'h44, 1'b0);
      step(1'b1, 8'h00, 8'h44, 8'h44, 1'b0);
      chk("a_run_cnt2b", {28'd0, dut.cnt_a}, 32'd2);
      chk("a_run_fault", {29'd0, fault}, 32'd0);
      chk("a_run_mode", {30'd0, mode}, 32'd0);

      // Asynchronous reset mid-stream.
      in_valid = 1'b1; ch_a = 8'h77; ch_b = 8'h77; ch_c = 8'h77;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_data", {24'd0, out_data}, 32'd0);
      chk("arst_cnt_a", {28'd0, dut.cnt_a}, 32'd0);
      @(posedge clk);
      #1;
      chk("arst_hold_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;

      // Limit of 1: two channels fail on one sample.
      step1(8'h01, 8'h02, 8'h03);
      chk("lim1_data", {24'd0, out_data1}, 32'h03);
      chk("lim1_fault", {29'd0, fault1}, 32'd3);
      chk("lim1_mode", {30'd0, mode1}, 32'd2);
      chk("lim1_err0", {31'd0, err1}, 32'd0);
      step1(8'h10, 8'h10, 8'h10);
      chk("fail_valid", {31'd0, out_valid1}, 32'd1);
      chk("fail_data", {24'd0, out_data1}, 32'h03);
      chk("fail_err", {31'd0, err1}, 32'd1);
      chk("fail_dis", {31'd0, disagree1}, 32'd0);
      chk("fail_mode", {30'd0, mode1}, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
